// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs loads/stores from the EXE/MEM slot over a req/ack data-memory port.
// Latency: ALU ops and misaligned ops retire 1 cycle later; memory ops retire 1 cycle after ack (2 minimum).
// Backpressure: stall holds upstream from acceptance until the completing (ack or timeout) cycle.
module mem_stage_ctrl #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_reg_write,
  input  logic        in_mem_to_reg,
  input  logic [31:0] in_alu_res,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_write_reg,
  input  logic [31:0] in_pc_plus4,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_write_reg,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc_plus4,
  output logic        err_misaligned,
  output logic        err_timeout
);

  localparam int CW = $clog2(MAX_WAIT) + 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state, next_state;
  logic [CW-1:0] wait_cnt;
  logic          mem_op, aligned, accept, timeout_hit;

  // Write-back fields captured at acceptance; the memory result is merged in at ack.
  logic          lat_mem_to_reg;
  logic          lat_reg_write;
  logic [4:0]    lat_write_reg;
  logic [31:0]   lat_alu_res;
  logic [31:0]   lat_pc_plus4;

  assign mem_op  = in_valid & (in_mem_read | in_mem_write);
  assign aligned = (in_alu_res[1:0] == 2'b00);

  // Next-state, stall and timeout decode.
  always_comb begin
    next_state  = state;
    stall       = 1'b0;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && aligned) begin
          accept     = 1'b1;
          stall      = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        // A late ack on the final count still completes normally.
        timeout_hit = (wait_cnt == CW'(MAX_WAIT - 1)) & ~dmem_ack;
        stall       = ~dmem_ack & ~timeout_hit;
        if (dmem_ack || timeout_hit) next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Wait counter: cleared on entry to ACCESS, counts ACCESS cycles without ack.
  always_ff @(posedge clock) begin
    if (reset || accept)                wait_cnt <= '0;
    else if (state == ACCESS && !dmem_ack) wait_cnt <= wait_cnt + 1'b1;
  end

  // Memory request: raised at acceptance, held stable until ack or timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else if (accept) begin
      dmem_req   <= 1'b1;
      dmem_we    <= in_mem_write;
      dmem_addr  <= {in_alu_res[31:2], 2'b00};
      dmem_wdata <= in_store_data;
    end else if (state == ACCESS && (dmem_ack || timeout_hit)) begin
      dmem_req   <= 1'b0;
    end
  end

  // Capture write-back fields of an accepted memory op; a store never takes memory data.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_mem_to_reg <= 1'b0;
      lat_reg_write  <= 1'b0;
      lat_write_reg  <= '0;
      lat_alu_res    <= '0;
      lat_pc_plus4   <= '0;
    end else if (accept) begin
      lat_mem_to_reg <= in_mem_to_reg & ~in_mem_write;
      lat_reg_write  <= in_reg_write;
      lat_write_reg  <= in_write_reg;
      lat_alu_res    <= in_alu_res;
      lat_pc_plus4   <= in_pc_plus4;
    end
  end

  // MEM/WB payload and error pulses; wb_valid pulses once per retired instruction.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid       <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_write_reg   <= '0;
      wb_data        <= '0;
      wb_pc_plus4    <= '0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      wb_valid       <= 1'b0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
      if (state == IDLE && in_valid && !accept) begin
        // ALU op, or a misaligned memory op that is dropped without a request.
        wb_valid       <= 1'b1;
        wb_reg_write   <= in_reg_write & ~mem_op;
        wb_write_reg   <= in_write_reg;
        wb_data        <= in_alu_res;
        wb_pc_plus4    <= in_pc_plus4;
        err_misaligned <= mem_op;
      end else if (state == ACCESS && dmem_ack) begin
        wb_valid       <= 1'b1;
        wb_reg_write   <= lat_reg_write;
        wb_write_reg   <= lat_write_reg;
        wb_data        <= lat_mem_to_reg ? dmem_rdata : lat_alu_res;
        wb_pc_plus4    <= lat_pc_plus4;
      end else if (timeout_hit) begin
        wb_valid       <= 1'b1;
        wb_reg_write   <= 1'b0;
        wb_write_reg   <= lat_write_reg;
        wb_data        <= lat_alu_res;
        wb_pc_plus4    <= lat_pc_plus4;
        err_timeout    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed cases then randomized instructions.
module tb_mem_stage_ctrl;
  localparam int MAX_WAIT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg;
  logic [31:0] in_alu_res, in_store_data, in_pc_plus4;
  logic [4:0]  in_write_reg;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, wb_valid, wb_reg_write, err_misaligned, err_timeout;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_data, wb_pc_plus4;

  int vectors = 0;
  int miscompares = 0;

  mem_stage_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_alu_res(in_alu_res), .in_store_data(in_store_data), .in_write_reg(in_write_reg),
    .in_pc_plus4(in_pc_plus4), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_data(wb_data), .wb_pc_plus4(wb_pc_plus4), .err_misaligned(err_misaligned),
    .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
    chk({tag, "_addr"}, dmem_addr, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata, 32'd0);
    chk({tag, "_wb"}, {25'd0, wb_valid, wb_reg_write, wb_write_reg}, 32'd0);
    chk({tag, "_wbdata"}, wb_data, 32'd0);
    chk({tag, "_wbpc"}, wb_pc_plus4, 32'd0);
    chk({tag, "_err"}, {30'd0, err_misaligned, err_timeout}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  // One instruction through the stage. d = ACCESS cycle (1-based) in which ack is given;
  // d > MAX_WAIT means the memory never answers.
  task automatic run_instr(input string tag, input logic rd, input logic wr, input logic rw,
                           input logic m2r, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [31:0] pc, input logic [4:0] wreg, input int d,
                           input logic [31:0] rdata, input logic idle_ack);
    logic mem, mis, tmo, exp_rw, stable, spurious, fin;
    int exp_stall, stall_cnt, req_cnt, acc;
    logic [31:0] exp_data;
    // Reference outcome straight from the stage rules.
    mem       = rd | wr;
    mis       = mem && (alu[1:0] != 2'b00);
    tmo       = mem && !mis && (d > MAX_WAIT);
    exp_stall = (!mem || mis) ? 0 : ((d > MAX_WAIT) ? MAX_WAIT : d);
    exp_rw    = (mis || tmo) ? 1'b0 : rw;
    exp_data  = (mem && !mis && !tmo && rd && !wr && m2r) ? rdata : alu;

    @(negedge clock);
    in_valid = 1'b1; in_mem_read = rd; in_mem_write = wr; in_reg_write = rw;
    in_mem_to_reg = m2r; in_alu_res = alu; in_store_data = sd; in_pc_plus4 = pc;
    in_write_reg = wreg; dmem_ack = idle_ack; dmem_rdata = $urandom;
    stall_cnt = 0; req_cnt = 0; acc = 0; stable = 1'b1; spurious = 1'b0; fin = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      if (c > 0) begin
        if (dmem_req) begin
          acc++;
          dmem_ack   = (acc == d);
          dmem_rdata = (acc == d) ? rdata : $urandom;
        end else begin
          dmem_ack = 1'b0;
        end
      end
      #1;
      if (dmem_req) begin
        req_cnt++;
        if (dmem_addr !== alu || dmem_we !== wr || (wr && dmem_wdata !== sd)) stable = 1'b0;
      end
      if (wb_valid || err_misaligned || err_timeout) spurious = 1'b1;
      if (!stall) fin = 1'b1;
      else stall_cnt++;
      @(posedge clock);
      #1;
      dmem_ack = 1'b0;
      if (fin) in_valid = 1'b0;
    end
    if (!fin) chk({tag, "_bound"}, 32'd0, 32'd1);
    chk({tag, "_stall_cycles"}, stall_cnt, exp_stall);
    chk({tag, "_req_cycles"}, req_cnt, exp_stall);
    chk({tag, "_req_stable"}, {31'd0, stable}, 32'd1);
    chk({tag, "_early_wb"}, {31'd0, spurious}, 32'd0);
    @(negedge clock);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, "_wb_rw"}, {31'd0, wb_reg_write}, {31'd0, exp_rw});
    chk({tag, "_wb_reg"}, {27'd0, wb_write_reg}, {27'd0, wreg});
    chk({tag, "_wb_pc"}, wb_pc_plus4, pc);
    chk({tag, "_err"}, {30'd0, err_misaligned, err_timeout}, {30'd0, mis, tmo});
    chk({tag, "_req_after"}, {31'd0, dmem_req}, 32'd0);
    if (!mis && !tmo) chk({tag, "_wb_data"}, wb_data, exp_data);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    in_reg_write = 1'b0; in_mem_to_reg = 1'b0; in_alu_res = '0; in_store_data = '0;
    in_write_reg = '0; in_pc_plus4 = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Directed cases.
    run_instr("alu", 0, 0, 1, 0, 32'h1234, 0, 32'h100, 5'd5, 1, 0, 1'b1);
    run_instr("load3", 1, 0, 1, 1, 32'h40, 0, 32'h104, 5'd8, 3, 32'hDEADBEEF, 1'b0);
    run_instr("store", 0, 1, 0, 0, 32'h10, 32'hA5A5A5A5, 32'h108, 5'd0, 1, 0, 1'b0);
    run_instr("misal", 1, 0, 1, 1, 32'h42, 0, 32'h10C, 5'd9, 1, 0, 1'b0);
    run_instr("timeout", 1, 0, 1, 1, 32'h80, 0, 32'h110, 5'd10, MAX_WAIT + 1, 0, 1'b0);
    run_instr("ack_last", 1, 0, 1, 1, 32'h84, 0, 32'h114, 5'd11, MAX_WAIT, 32'hCAFEF00D, 1'b0);
    run_instr("rdwr", 1, 1, 1, 1, 32'h88, 32'h5555AAAA, 32'h118, 5'd12, 2, 32'h77777777, 1'b0);

    // Reset in the second ACCESS cycle, ack arriving one cycle later.
    @(negedge clock);
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_reg_write = 1'b1;
    in_mem_to_reg = 1'b1; in_alu_res = 32'h40; in_write_reg = 5'd3;
    @(negedge clock);
    chk("rst_mid_req_a1", {31'd0, dmem_req}, 32'd1);
    @(negedge clock);
    chk("rst_mid_req_a2", {31'd0, dmem_req}, 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0; in_valid = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    @(negedge clock);
    check_idle_outputs("rst_mid");
    @(posedge clock);
    #1;
    dmem_ack = 1'b0;
    @(negedge clock);
    check_idle_outputs("rst_late");

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      run_instr("rand", (kind == 1 || kind == 3), (kind == 2 || kind == 3),
                1'($urandom), (kind == 1 || kind == 3), a, $urandom, $urandom,
                5'($urandom), $urandom_range(1, MAX_WAIT + 2), $urandom, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
